// File: rtl/adder_rr_arbiter_if.sv
// Requester-side bundle of the shared-adder arbiter: operand handshake in,
// one-hot response pulse plus shared sum out.
interface adder_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_x;
  logic [N_REQ*W-1:0] req_y;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W:0]         rsp_sum;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer sharing one pipelined W-bit adder among N_REQ requesters;
// a tag pipeline follows each operation so the sum returns to its owner.
module adder_rr_lane #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] xg,
  output logic [W-1:0] yg
);
  assign xg = x & {W{sel}};
  assign yg = y & {W{sel}};
endmodule

module adder_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int ADD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  adder_rr_arbiter_if.slave   bus,
  input  logic                halt,
  output logic [W-1:0]        add_x,
  output logic [W-1:0]        add_y,
  input  logic [W:0]          add_s,
  output logic                busy,
  output logic [31:0]         ops_done
);
  localparam int IDW    = $clog2(N_REQ);
  localparam int STAGES = ADD_LAT;

  logic [IDW-1:0]              ptr, gidx;
  logic [N_REQ-1:0]            hi, pick, gnt;
  logic                        xfer;
  logic [N_REQ-1:0][W-1:0]     lx, ly, xg, yg;
  logic [W-1:0]                mux_x, mux_y;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][IDW-1:0]    id_pipe;

  assign lx = bus.req_x;
  assign ly = bus.req_y;

  // Masked priority: requesters at or above ptr win first, else wrap to the lowest.
  always_comb begin
    hi   = bus.req_valid & ({N_REQ{1'b1}} << ptr);
    pick = (|hi) ? hi : bus.req_valid;
    gnt  = halt ? '0 : (pick & (~pick + N_REQ'(1)));
  end

  assign bus.req_ready = gnt;
  assign xfer          = |(gnt & bus.req_valid);

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    adder_rr_lane #(.W(W)) u_lane (
      .sel (gnt[i]),
      .x   (lx[i]),
      .y   (ly[i]),
      .xg  (xg[i]),
      .yg  (yg[i])
    );
  end

  // gnt is one-hot, so OR-reduction of the gated lanes is the operand mux.
  always_comb begin
    mux_x = '0;
    mux_y = '0;
    gidx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mux_x = mux_x | xg[i];
      mux_y = mux_y | yg[i];
      if (gnt[i]) gidx = gidx | IDW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      add_x         <= '0;
      add_y         <= '0;
      vld_pipe      <= '0;
      id_pipe       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_sum   <= '0;
      ops_done      <= '0;
    end else begin
      if (xfer) begin
        add_x <= mux_x;
        add_y <= mux_y;
        ptr   <= (gidx == IDW'(N_REQ-1)) ? '0 : gidx + IDW'(1);
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], xfer};
      id_pipe  <= {id_pipe[STAGES-1:0], gidx};
      // The last tag stage lines up with add_s for the operation it tracks.
      if (vld_pipe[STAGES]) begin
        bus.rsp_valid <= N_REQ'(1) << id_pipe[STAGES];
        bus.rsp_sum   <= add_s;
        ops_done      <= ops_done + 32'd1;
      end else begin
        bus.rsp_valid <= '0;
      end
    end
  end

  assign busy = |vld_pipe;
endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one registered 32-bit adder (the brent_kung_32b datapath, reached through the add_* ports) among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block issues at most one operation per cycle to the adder and tracks every in-flight operation with a tag pipeline. It returns the 33-bit sum to the originating requester as a one-cycle response pulse. It sits between the requester ports and the adder instance and owns all sequencing of the adder.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- W, 32: operand width; sums are W+1 bits.
- ADD_LAT, 1: adder latency in clk edges from add_x/add_y change to add_s valid, ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_x  in  N_REQ*W  operand x; requester i uses bits [i*W +: W].
- req_y  in  N_REQ*W  operand y, same packing.
- req_ready  out  N_REQ  one-hot grant, combinational.
- halt  in  1  when high, no new grants are issued.
- add_x  out  W  registered operand to the adder.
- add_y  out  W  registered operand to the adder.
- add_s  in  W+1  adder sum.
- rsp_valid  out  N_REQ  one-hot response pulse, registered.
- rsp_sum  out  W+1  response sum, registered, shared by all requesters.
- busy  out  1  high while any operation is in flight.
- ops_done  out  32  count of responses issued; wraps at 2^32.

## Operation
- Grant (combinational):
  - If halt=0 and any req_valid is set, req_ready[g]=1 for exactly one g.
  - g is the first set req_valid found scanning upward from ptr, wrapping N_REQ-1→0.
  - All other req_ready bits are 0. req_ready=0 whenever halt=1 or no req_valid is set.
- Handshake: a transfer occurs in a cycle where req_valid[g]&req_ready[g]. Requesters hold x, y and valid until the transfer.
- On a transfer edge:
  - add_x<=req_x[g], add_y<=req_y[g].
  - ptr<=(g+1) mod N_REQ.
  - Tag stage 0 <= {1, g}.
- Without a transfer, add_x/add_y hold their values and tag stage 0 valid <= 0. ptr changes only on a transfer.
- Tag pipeline: ADD_LAT+1 stages {valid, id}, shifting every edge. It has no stall: the adder is fully pipelined, so throughput is one operation per cycle.
- Response: when the last tag stage is valid:
  - rsp_sum<=add_s.
  - rsp_valid<=onehot(id) for one cycle.
  - ops_done<=ops_done+1.
  - Otherwise rsp_valid<=0 and rsp_sum holds.
- Responses carry no backpressure; requesters must accept them.
- busy = OR of all tag-stage valid bits.
- halt mid-stream stops new grants only. In-flight operations complete and respond normally.
- Arithmetic: the sum is the full W+1 bits with no truncation. Sums that overflow W bits set bit W.

## Timing
- Reset values: add_x=0, add_y=0, all tag valids=0, ptr=0, rsp_valid=0, rsp_sum=0, ops_done=0, busy=0.
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. The first grant after release goes to the lowest-index valid requester.
- Latency: a transfer in cycle t produces rsp_valid in cycle t+ADD_LAT+2, which is t+3 at default parameters.
- Back-to-back: transfers in consecutive cycles produce responses in consecutive cycles, in grant order.
- req_ready settles combinationally in the same cycle from req_valid, ptr and halt.
- Simultaneous response and transfer in one cycle are independent; both take effect.
- ops_done increments on the same edge that sets rsp_valid.

## Test plan
- Reset then single request: requester 2 sends x=0x0000_0005, y=0x0000_0007 at cycle t → req_ready=0100 in cycle t, rsp_valid=0100 and rsp_sum=12 in cycle t+3, ops_done=1.
- Round-robin: all 4 requesters held valid with distinct operands → grants 0,1,2,3,0 in consecutive cycles; responses arrive in the same order, one per cycle, each sum correct.
- Overflow: x=0xFFFF_FFFF, y=0x0000_0001 → rsp_sum=0x1_0000_0000; x=y=0xFFFF_FFFF → rsp_sum=0x1_FFFF_FFFE.
- Halt: with 3 operations in flight, assert halt → req_ready=0 while halt is high; all 3 responses still arrive; busy falls after the last one; grants resume from ptr when halt is released.
- Reset mid-flight: issue 2 operations, assert rst asynchronously 1 cycle later → no rsp_valid ever appears for them; ops_done=0, ptr=0, add_x=add_y=0.
- Random soak: 100000 random requests from random requesters, compared against x+y reference → zero mismatches, no response lost or duplicated, ops_done equals the number of transfers.
